pll_lock_sequencer: RTL

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings a PLL out of power-down, qualifies its lock indication, and then
//   releases reset to the PLL-clocked fabric. If the PLL does not lock, the
//   attempt is retried a bounded number of times before a sticky fault is
//   raised. Every decision uses a two-flop synchronized copy of PLL_LOCK.
//
//   Optional build macro: PLL_SEQ_RELOCK_EN
//     defined   : lock loss in STRETCH/RUN returns to WAIT_LOCK. The PLL stays
//                 powered and RETRY_COUNT is kept.
//     undefined : lock loss in STRETCH/RUN goes straight to FAULT.
//
//   Ports
//     CLK              in   free-running reference clock (not from the PLL)
//     RESET_N          in   asynchronous active-low reset
//     ENABLE           in   1 = bring up and keep the PLL running, 0 = power down
//     PLL_LOCK         in   raw PLL lock, asynchronous to CLK
//     PLL_POWERDOWN_N  out  PLL power-down pin, active low
//     FABRIC_RESET_N   out  active-low reset for PLL-clocked logic
//     LOCKED           out  filtered, qualified lock status
//     FAULT            out  sticky bring-up failure flag
//     RETRY_COUNT[1:0] out  failed attempts in the current bring-up
//     STATE[2:0]       out  IDLE=0 PWRDN=1 WAIT_LOCK=2 FILTER=3 STRETCH=4
//                           RUN=5 FAULT=6

module pll_lock_sequencer #(
   parameter int unsigned PWRDN_CYCLES = 16,
   parameter int unsigned LOCK_FILTER  = 64,
   parameter int unsigned LOCK_TIMEOUT = 50000,
   parameter int unsigned MAX_RETRIES  = 3,
   parameter int unsigned RST_STRETCH  = 32
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       ENABLE,
   input  logic       PLL_LOCK,
   output logic       PLL_POWERDOWN_N,
   output logic       FABRIC_RESET_N,
   output logic       LOCKED,
   output logic       FAULT,
   output logic [1:0] RETRY_COUNT,
   output logic [2:0] STATE
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PWRDN     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_FILTER    = 3'd3,
      ST_STRETCH   = 3'd4,
      ST_RUN       = 3'd5,
      ST_FAULT     = 3'd6
   } state_t;

   // Terminal values. A phase ends on the cycle its counter holds N-1, so the
   // phase occupies exactly N cycles.
   localparam logic [9:0]  PWRDN_LAST   = 10'(PWRDN_CYCLES - 1);
   localparam logic [9:0]  FILTER_LAST  = 10'(LOCK_FILTER - 1);
   localparam logic [9:0]  STRETCH_LAST = 10'(RST_STRETCH - 1);
   localparam logic [15:0] TMO_LAST     = 16'(LOCK_TIMEOUT - 1);
   localparam logic [1:0]  RETRY_MAX    = 2'(MAX_RETRIES);

`ifdef PLL_SEQ_RELOCK_EN
   localparam state_t LOSS_STATE = ST_WAIT_LOCK;
`else
   localparam state_t LOSS_STATE = ST_FAULT;
`endif

   state_t      state, state_nx;
   logic        lock_meta, lock_s;
   logic [9:0]  phase_cnt, phase_cnt_nx;
   logic [15:0] tmo_cnt, tmo_cnt_nx;
   logic [1:0]  retry_nx;
   logic        timeout;
   logic        retry_req;
   logic        in_lock_wait, nx_lock_wait;

   // Two-flop lock synchronizer.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= PLL_LOCK;
         lock_s    <= lock_meta;
      end
   end

   always_comb begin
      state_nx  = state;
      retry_nx  = RETRY_COUNT;
      retry_req = 1'b0;
      timeout   = (tmo_cnt == TMO_LAST);

      if (state != ST_IDLE && !ENABLE) begin
         // Disable overrides lock, timeout and counter events in the same cycle.
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:      if (ENABLE) state_nx = ST_PWRDN;
            ST_PWRDN:     if (phase_cnt == PWRDN_LAST) state_nx = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
               if (timeout)     retry_req = 1'b1;
               else if (lock_s) state_nx  = ST_FILTER;
            end
            ST_FILTER: begin
               if (lock_s && phase_cnt == FILTER_LAST) state_nx  = ST_STRETCH;
               else if (timeout)                       retry_req = 1'b1;
               else if (!lock_s)                       state_nx  = ST_WAIT_LOCK;
            end
            ST_STRETCH: begin
               if (!lock_s)                         state_nx = LOSS_STATE;
               else if (phase_cnt == STRETCH_LAST)  state_nx = ST_RUN;
            end
            ST_RUN:       if (!lock_s) state_nx = LOSS_STATE;
            ST_FAULT:     state_nx = ST_FAULT;
            default:      state_nx = ST_IDLE;
         endcase
      end

      if (retry_req) begin
         if (RETRY_COUNT < RETRY_MAX) begin
            retry_nx = (RETRY_COUNT == 2'd3) ? 2'd3 : RETRY_COUNT + 2'd1;
            state_nx = ST_PWRDN;
         end else begin
            state_nx = ST_FAULT;
         end
      end

      if (state_nx == ST_IDLE || state_nx == ST_RUN) retry_nx = '0;

      // The phase counter restarts on every state change. It serves PWRDN,
      // FILTER and STRETCH, which are mutually exclusive.
      if (state_nx == state &&
          (state == ST_PWRDN || state == ST_FILTER || state == ST_STRETCH))
         phase_cnt_nx = phase_cnt + 10'd1;
      else
         phase_cnt_nx = '0;

      // The timeout keeps running across FILTER<->WAIT_LOCK bounces. It
      // restarts on any entry from outside that pair.
      in_lock_wait = (state == ST_WAIT_LOCK || state == ST_FILTER);
      nx_lock_wait = (state_nx == ST_WAIT_LOCK || state_nx == ST_FILTER);
      tmo_cnt_nx   = (in_lock_wait && nx_lock_wait) ? tmo_cnt + 16'd1 : '0;
   end

   // Outputs are decoded from the next state and then registered, so they
   // change on the same edge as STATE.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state           <= ST_IDLE;
         phase_cnt       <= '0;
         tmo_cnt         <= '0;
         RETRY_COUNT     <= '0;
         PLL_POWERDOWN_N <= 1'b0;
         FABRIC_RESET_N  <= 1'b0;
         LOCKED          <= 1'b0;
         FAULT           <= 1'b0;
      end else begin
         state           <= state_nx;
         phase_cnt       <= phase_cnt_nx;
         tmo_cnt         <= tmo_cnt_nx;
         RETRY_COUNT     <= retry_nx;
         PLL_POWERDOWN_N <= (state_nx == ST_WAIT_LOCK || state_nx == ST_FILTER ||
                             state_nx == ST_STRETCH   || state_nx == ST_RUN);
         LOCKED          <= (state_nx == ST_STRETCH || state_nx == ST_RUN);
         FABRIC_RESET_N  <= (state_nx == ST_RUN);
         FAULT           <= (state_nx == ST_FAULT);
      end
   end

   assign STATE = state;

endmodule
